arith_result_stage: RTL and testbench

Parametrised, registered result-formatting stage between the adder/subtractor and the ALU result bus. Turns raw adder output into the final arithmetic result: pass-through, signed/unsigned set-less-than with overflow correction, and byte/halfword sign/zero extension. Results are buffered in a 2-entry skid buffer behind a valid/ready handshake, so the ALU can be pipelined and stalled without losing data.

---
 rtl/arith_result_stage.sv | 138 +++++++++++++
 tb/tb_arith_result_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/arith_result_stage.sv
// arith_result_stage
// Formats raw adder/subtractor output into the final arithmetic result:
// pass-through, signed/unsigned set-less-than, and byte/halfword sign/zero
// extension. Formatted results sit in a 2-entry skid buffer behind a
// valid/ready handshake, so the ALU can be pipelined and stalled without
// losing data.
//
// Optional feature macro: ARITH_RESULT_SLT_OVF_EN
//   defined   : signed SLT corrects the sign bit for two's-complement overflow
//   undefined : legacy signed SLT, result taken from the raw sum sign bit only

module arith_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry_out,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic [WIDTH-1:0] formatted;
  logic             formattedZero;
  logic             sltLess;
  logic             push;
  logic             pop;

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             headZero_q, headZero_d;
  logic             tailZero_q, tailZero_d;

`ifdef ARITH_RESULT_SLT_OVF_EN
  logic sltOverflow;

  // Operands of differing sign can overflow the subtraction; when they do the
  // sum sign bit is inverted relative to the true comparison.
  assign sltOverflow = (a_msb != b_msb) & (sum[WIDTH-1] != a_msb);
  assign sltLess     = sum[WIDTH-1] ^ sltOverflow;
`else
  logic unusedOperandMsbs;

  // Legacy compare trusts the raw sign bit; operand MSBs play no part.
  assign sltLess           = sum[WIDTH-1];
  assign unusedOperandMsbs = a_msb ^ b_msb;
`endif

  // Format the incoming adder output according to the requested mode.
  always_comb begin
    formatted = sum;
    case (mode)
      3'b001:  formatted = {{(WIDTH-1){1'b0}}, sltLess};
      3'b010:  formatted = {{(WIDTH-1){1'b0}}, ~carry_out};
      3'b011:  formatted = {{(WIDTH-8){sum[7]}}, sum[7:0]};
      3'b100:  formatted = {{(WIDTH-8){1'b0}}, sum[7:0]};
      3'b101:  formatted = {{(WIDTH-16){sum[15]}}, sum[15:0]};
      3'b110:  formatted = {{(WIDTH-16){1'b0}}, sum[15:0]};
      default: formatted = sum;
    endcase
  end

  assign formattedZero = (formatted == '0);

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign result    = head_q;
  assign zero      = headZero_q;

  // Buffer next state: the head always feeds the output, the tail only fills
  // when a push arrives while the head is still waiting to be taken.
  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    headZero_d = headZero_q;
    tailZero_d = tailZero_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d     = formatted;
          headZero_d = formattedZero;
          count_d    = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d     = formatted;
          headZero_d = formattedZero;
        end else if (push) begin
          tail_d     = formatted;
          tailZero_d = formattedZero;
          count_d    = 2'd2;
        end else if (pop) begin
          count_d    = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d     = tail_q;
          headZero_d = tailZero_q;
          count_d    = 2'd1;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
  end

  // Buffer storage; reset discards every entry immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      headZero_q <= 1'b0;
      tailZero_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      headZero_q <= headZero_d;
      tailZero_q <= tailZero_d;
    end
  end

endmodule

// File: tb/tb_arith_result_stage.sv
// tb_arith_result_stage
// Directed-vector bench for arith_result_stage. Stimulus pushes the
// hand-computed result for each accepted input into a scoreboard queue; an
// independent monitor pops and compares whenever the stage hands a result
// downstream. Expected SLT overflow behaviour follows ARITH_RESULT_SLT_OVF_EN.

module tb_arith_result_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sum;
  logic        carry_out;
  logic        a_msb;
  logic        b_msb;
  logic [2:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checkCount;
  int passCount;

  logic [32:0] expectedQueue[$];

  logic        holdActive;
  logic [31:0] holdResult;
  logic        holdZero;

  arith_result_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .a_msb     (a_msb),
    .b_msb     (b_msb),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point shared by the directed checks and the monitor.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Offer one input and record its expected formatted result once accepted.
  task automatic applyStimulus(input logic [31:0] s, input logic co,
                               input logic am, input logic bm,
                               input logic [2:0] m, input logic [31:0] expected);
    int waitCycles;
    waitCycles = 0;
    in_valid  = 1'b1;
    sum       = s;
    carry_out = co;
    a_msb     = am;
    b_msb     = bm;
    mode      = m;
    @(negedge clk);
    while (!in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 32'(in_ready), 32'd1);
    end else begin
      expectedQueue.push_back({(expected == 32'd0), expected});
    end
    @(posedge clk);
    #1;
  endtask

  // Wait, with a bound, until every expected result has been taken.
  task automatic waitDrain();
    int waitCycles;
    waitCycles = 0;
    while ((expectedQueue.size() != 0 || out_valid) && waitCycles < 50) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (expectedQueue.size() != 0 || out_valid) begin
      checkOutput("drainTimeout", 32'(expectedQueue.size()), 32'd0);
    end
  endtask

  // Monitor: compare each handed-off result with the scoreboard head and
  // check that a stalled head holds steady.
  always @(negedge clk) begin
    logic [32:0] expectedEntry;
    if (reset) begin
      holdActive = 1'b0;
    end else begin
      if (holdActive) begin
        checkOutput("holdValid", 32'(out_valid), 32'd1);
        checkOutput("holdResult", result, holdResult);
        checkOutput("holdZero", 32'(zero), 32'(holdZero));
      end
      if (out_valid && out_ready) begin
        if (expectedQueue.size() == 0) begin
          checkOutput("unexpectedOutput", result, 32'hxxxxxxxx);
        end else begin
          expectedEntry = expectedQueue.pop_front();
          checkOutput("result", result, expectedEntry[31:0]);
          checkOutput("zero", 32'(zero), 32'(expectedEntry[32]));
        end
      end
      holdActive = out_valid && !out_ready;
      holdResult = result;
      holdZero   = zero;
    end
  end

  initial begin
    logic [31:0] sltOvfExpected;
`ifdef ARITH_RESULT_SLT_OVF_EN
    sltOvfExpected = 32'h0000_0000;
`else
    sltOvfExpected = 32'h0000_0001;
`endif
    checkCount = 0;
    passCount  = 0;
    holdActive = 1'b0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    sum        = '0;
    carry_out  = 1'b0;
    a_msb      = 1'b0;
    b_msb      = 1'b0;
    mode       = 3'b000;
    out_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetOutValid", 32'(out_valid), 32'd0);
    checkOutput("resetInReady", 32'(in_ready), 32'd1);
    checkOutput("resetResult", result, 32'd0);
    checkOutput("resetZero", 32'(zero), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idleOutValid", 32'(out_valid), 32'd0);

    $display("[TB] formatting vectors");
    applyStimulus(32'h1234_5678, 1'b0, 1'b0, 1'b0, 3'b000, 32'h1234_5678);
    applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 3'b001, sltOvfExpected);
    applyStimulus(32'h8000_0000, 1'b0, 1'b1, 1'b1, 3'b001, 32'h0000_0001);
    applyStimulus(32'h0000_0005, 1'b1, 1'b0, 1'b0, 3'b001, 32'h0000_0000);
    applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0000_0001);
    applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0000);
    applyStimulus(32'h0001_8080, 1'b0, 1'b0, 1'b0, 3'b011, 32'hFFFF_FF80);
    applyStimulus(32'h0001_8080, 1'b0, 1'b0, 1'b0, 3'b100, 32'h0000_0080);
    applyStimulus(32'h0001_8080, 1'b0, 1'b0, 1'b0, 3'b101, 32'hFFFF_8080);
    applyStimulus(32'h0001_8080, 1'b0, 1'b0, 1'b0, 3'b110, 32'h0000_8080);
    applyStimulus(32'h0001_7F7F, 1'b0, 1'b0, 1'b0, 3'b011, 32'h0000_007F);
    applyStimulus(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 3'b111, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    waitDrain();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(32'd5, 1'b0, 1'b0, 1'b0, 3'b000, 32'd5);
    checkOutput("bpInReadyOne", 32'(in_ready), 32'd1);
    applyStimulus(32'd6, 1'b0, 1'b0, 1'b0, 3'b000, 32'd6);
    checkOutput("bpInReadyFull", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    sum      = 32'd7;
    mode     = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("bpStillFull", 32'(in_ready), 32'd0);
    checkOutput("bpHeadHeld", result, 32'd5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bpInReadyBack", 32'(in_ready), 32'd1);
    checkOutput("bpSecondHead", result, 32'd6);
    waitDrain();
    checkOutput("bpNoThird", 32'(out_valid), 32'd0);

    $display("[TB] streaming");
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(32'(i), 1'b0, 1'b0, 1'b0, 3'b000, 32'(i));
      checkOutput("streamOutValid", 32'(out_valid), 32'd1);
      checkOutput("streamInReady", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    waitDrain();

    $display("[TB] reset with two entries buffered");
    out_ready = 1'b0;
    applyStimulus(32'h0000_00AA, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_00AA);
    applyStimulus(32'h0000_00BB, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_00BB);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midResetOutValid", 32'(out_valid), 32'd0);
    checkOutput("midResetInReady", 32'(in_ready), 32'd1);
    checkOutput("midResetResult", result, 32'd0);
    checkOutput("midResetZero", 32'(zero), 32'd0);
    expectedQueue.delete();
    @(posedge clk);
    #3;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(32'h0000_0000, 1'b0, 1'b0, 1'b0, 3'b100, 32'h0000_0000);
    in_valid = 1'b0;
    waitDrain();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
